// File: rtl/complex_bin_accumulator_pkg.sv
// Shared types and constants for the frequency-domain bin accumulator.
// complex_t carries one fp32 complex sample as {r, i}.
package complex_bin_accumulator_pkg;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] i;
    } complex_t;

    localparam int          FP_ADD_LAT = 11;
    localparam int          FP_MUL_LAT = 8;
    localparam logic [31:0] FP_ZERO    = 32'h0;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } acc_state_t;

    function automatic logic isPow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/complex_bin_accumulator_if.sv
// Sample stream into the accumulator and summed frame stream out to the IFFT.
// The master drives the product stream; the slave is the accumulator.
interface complex_bin_accumulator_if;
    import complex_bin_accumulator_pkg::*;

    logic     clear;
    complex_t in;
    logic     in_valid;
    logic     next;
    complex_t out;
    logic     out_valid;
    logic     next_out;
    logic     busy;
    logic     err;

    modport master (
        output clear, in, in_valid, next,
        input  out, out_valid, next_out, busy, err
    );

    modport slave (
        input  clear, in, in_valid, next,
        output out, out_valid, next_out, busy, err
    );

endinterface

// File: rtl/addfp32.sv
// fp32 adder with fixed FP_ADD_LAT latency, round-to-nearest-even.
// Denormals are flushed to zero; Inf/NaN operands pass through. Data path has no reset.
module addfp32
    import complex_bin_accumulator_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    function automatic logic [31:0] fpAdd(input logic [31:0] opA, input logic [31:0] opB);
        logic [31:0] x, y;
        logic [7:0]  sh;
        logic [26:0] mx, my;
        logic [53:0] ext;
        logic [27:0] acc;
        logic [9:0]  e;
        logic [4:0]  lz;
        logic        found;
        logic        sign;
        logic        rup;
        logic [24:0] mr;
        if (opA[30:23] == 8'hFF) return opA;
        if (opB[30:23] == 8'hFF) return opB;
        if (opA[30:23] == 8'h00 && opB[30:23] == 8'h00) return FP_ZERO;
        if (opA[30:23] == 8'h00) return opB;
        if (opB[30:23] == 8'h00) return opA;
        if (opA[30:0] >= opB[30:0]) begin
            x = opA;
            y = opB;
        end else begin
            x = opB;
            y = opA;
        end
        sign = x[31];
        sh   = x[30:23] - y[30:23];
        mx   = {1'b1, x[22:0], 3'b000};
        my   = {1'b1, y[22:0], 3'b000};
        // Alignment keeps guard/round bits plus a sticky bit for correct RNE.
        if (sh > 8'd26) begin
            my = 27'd1;
        end else begin
            ext = {my, 27'd0} >> sh;
            my  = ext[53:27] | {26'd0, |ext[26:0]};
        end
        e = {2'b00, x[30:23]};
        if (x[31] == y[31]) begin
            acc = {1'b0, mx} + {1'b0, my};
            if (acc[27]) begin
                acc = {1'b0, acc[27:2], acc[1] | acc[0]};
                e   = e + 10'd1;
            end
        end else begin
            acc = {1'b0, mx} - {1'b0, my};
            if (acc == 28'd0) return FP_ZERO;
            lz    = 5'd0;
            found = 1'b0;
            for (int k = 26; k >= 0; k--) begin
                if (!found) begin
                    if (acc[k]) found = 1'b1;
                    else        lz = lz + 5'd1;
                end
            end
            acc = acc << lz;
            e   = e - {5'd0, lz};
            if (e[9] || e == 10'd0) return {sign, 31'd0};
        end
        rup = acc[2] & (acc[1] | acc[0] | acc[3]);
        mr  = {1'b0, acc[26:3]} + {24'd0, rup};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        if (e >= 10'd255) return {sign, 8'hFF, 23'd0};
        return {sign, e[7:0], mr[22:0]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < FP_ADD_LAT; gi++) begin : gStage
            logic [31:0] sumReg;
            if (gi == 0) begin : gHead
                always_ff @(posedge clk) sumReg <= fpAdd(a, b);
            end else begin : gBody
                always_ff @(posedge clk) sumReg <= gStage[gi-1].sumReg;
            end
        end
    endgenerate

    assign sum = gStage[FP_ADD_LAT-1].sumReg;

endmodule

// File: rtl/complex_bin_accumulator_ram.sv
// Bin buffer: one synchronous read port and one write port.
// Read-during-write to the same address returns old data; callers never rely on it.
module acc_bin_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/complex_bin_accumulator.sv
// Sums NUM_CH consecutive FFT frames bin-by-bin and emits the total frame with next_out on bin 0.
// Read-add-write of a bin completes before that bin is read again because FFT_N > ADD_LAT+1.
module complex_bin_accumulator
    import complex_bin_accumulator_pkg::*;
#(
    parameter int FFT_N   = 16,
    parameter int NUM_CH  = 3,
    parameter int ADD_LAT = FP_ADD_LAT
) (
    input logic                      clk,
    input logic                      reset,
    complex_bin_accumulator_if.slave bus
);

    localparam int AW   = $clog2(FFT_N);
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PIPE = ADD_LAT + 1;
    localparam logic [AW-1:0] LAST_BIN = AW'(FFT_N - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

    generate
        if (!isPow2(FFT_N)) begin : gBadPow2
            $error("FFT_N must be a power of two");
        end
        if (FFT_N <= ADD_LAT + 1) begin : gBadDepth
            $error("FFT_N must exceed ADD_LAT+1");
        end
        if (NUM_CH < 1) begin : gBadCh
            $error("NUM_CH must be at least 1");
        end
        if (ADD_LAT != FP_ADD_LAT) begin : gBadLat
            $error("ADD_LAT must match the adder latency");
        end
    endgenerate

    typedef struct packed {
        logic          valid;
        logic          lastCh;
        logic          firstBin;
        logic [AW-1:0] addr;
    } ctl_t;

    acc_state_t    stateReg;
    logic [AW-1:0] binCntReg;
    logic [CW-1:0] chCntReg;
    logic          errReg;
    logic          firstChDlyReg;
    complex_t      inDlyReg;
    complex_t      ramRd;
    complex_t      accOp;
    complex_t      sum;
    logic [31:0]   sumR, sumI;
    complex_t      outReg;
    logic          outValidReg;
    logic          nextOutReg;
    logic          accept;
    ctl_t          ctlIn;
    ctl_t          ctlTail;
    logic [PIPE-1:0] validVec;
    logic          wrEn;
    logic          emit;

    assign accept = bus.in_valid & ~bus.clear;

    // Frame/channel sequencing; protocol errors are flagged but the sample is still used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg      <= IDLE;
            binCntReg     <= '0;
            chCntReg      <= '0;
            errReg        <= 1'b0;
            firstChDlyReg <= 1'b0;
        end else if (bus.clear) begin
            stateReg  <= IDLE;
            binCntReg <= '0;
            chCntReg  <= '0;
        end else if (bus.in_valid) begin
            firstChDlyReg <= (chCntReg == '0);
            if (stateReg == FRAME && bus.next && binCntReg != '0) begin
                errReg <= 1'b1;
            end
            if (stateReg == IDLE && !bus.next && binCntReg == '0) begin
                errReg <= 1'b1;
            end
            if (binCntReg == LAST_BIN) begin
                binCntReg <= '0;
                stateReg  <= IDLE;
                chCntReg  <= (chCntReg == LAST_CH) ? '0 : chCntReg + CW'(1);
            end else begin
                binCntReg <= binCntReg + AW'(1);
                stateReg  <= FRAME;
            end
        end
    end

    assign ctlIn = '{valid: accept, lastCh: (chCntReg == LAST_CH),
                     firstBin: (binCntReg == '0), addr: binCntReg};

    genvar gi;
    generate
        for (gi = 0; gi < PIPE; gi++) begin : gCtl
            ctl_t stageReg;
            if (gi == 0) begin : gHead
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset)         stageReg <= '0;
                    else if (bus.clear) stageReg <= '0;
                    else                stageReg <= ctlIn;
                end
            end else begin : gBody
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset)         stageReg <= '0;
                    else if (bus.clear) stageReg <= '0;
                    else                stageReg <= gCtl[gi-1].stageReg;
                end
            end
            assign validVec[gi] = stageReg.valid;
        end
    endgenerate

    assign ctlTail = gCtl[PIPE-1].stageReg;

    always_ff @(posedge clk) begin
        inDlyReg <= bus.in;
    end

    acc_bin_ram #(
        .DEPTH(FFT_N),
        .WIDTH(64)
    ) uRam (
        .clk    (clk),
        .rdAddr (binCntReg),
        .rdData (ramRd),
        .wrEn   (wrEn),
        .wrAddr (ctlTail.addr),
        .wrData (sum)
    );

    // Channel 0 ignores whatever the RAM holds, so stale sums never need clearing.
    assign accOp = firstChDlyReg ? {FP_ZERO, FP_ZERO} : ramRd;

    addfp32 uAddR (.clk(clk), .a(inDlyReg.r), .b(accOp.r), .sum(sumR));
    addfp32 uAddI (.clk(clk), .a(inDlyReg.i), .b(accOp.i), .sum(sumI));

    assign sum  = {sumR, sumI};
    assign wrEn = ctlTail.valid & ~ctlTail.lastCh & ~bus.clear;
    assign emit = ctlTail.valid &  ctlTail.lastCh & ~bus.clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outReg      <= '0;
            outValidReg <= 1'b0;
            nextOutReg  <= 1'b0;
        end else begin
            outValidReg <= emit;
            nextOutReg  <= emit & ctlTail.firstBin;
            if (emit) begin
                outReg <= sum;
            end
        end
    end

    assign bus.out       = outReg;
    assign bus.out_valid = outValidReg;
    assign bus.next_out  = nextOutReg;
    assign bus.err       = errReg;
    assign bus.busy      = (stateReg == FRAME) | (chCntReg != '0) | (|validVec);

endmodule

// File: tb/tb_complex_bin_accumulator.sv
// Directed bench: three-channel accumulator plus a single-channel pass-through instance.
module tb_complex_bin_accumulator;
    import complex_bin_accumulator_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    complex_bin_accumulator_if ifc ();
    complex_bin_accumulator_if ifc1 ();

    complex_bin_accumulator #(.FFT_N(16), .NUM_CH(3), .ADD_LAT(11)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave));
    complex_bin_accumulator #(.FFT_N(16), .NUM_CH(1), .ADD_LAT(11)) dut1 (
        .clk(clk), .reset(reset), .bus(ifc1.slave));

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        nxt;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.out_valid === 1'b1)  q0.push_back('{cyc, ifc.out, ifc.next_out});
        if (ifc1.out_valid === 1'b1) q1.push_back('{cyc, ifc1.out, ifc1.next_out});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fp(input int k);
        logic [31:0] kk;
        int p;
        kk = k;
        if (kk == 0) return 32'h0;
        p = 0;
        for (int j = 0; j < 32; j++) if (kk[j]) p = j;
        return {1'b0, 8'(127 + p), 23'((kk << (23 - p)) & 32'h007F_FFFF)};
    endfunction

    task automatic drive(input logic v, input logic n, input logic c, input logic [31:0] r, input logic [31:0] i);
        @(negedge clk);
        ifc.in_valid = v;
        ifc.next     = n;
        ifc.clear    = c;
        ifc.in       = {r, i};
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // mode 0: r=1.0, i=2.0; mode 1: r=k, i=2.0
    task automatic sendFrame(input int mode, input int gapPct, output int bin0Cyc);
        bin0Cyc = 0;
        for (int k = 0; k < 16; k++) begin
            while ($urandom_range(99) < gapPct) idle(1);
            drive(1'b1, k == 0, 1'b0, (mode == 0) ? 32'h3F80_0000 : fp(k), 32'h4000_0000);
            if (k == 0) bin0Cyc = cyc + 1;
        end
    endtask

    task automatic expectFrame(input string tag, input int mode, input int startCyc);
        idle(20);
        check({tag, "_count"}, 64'(q0.size()), 64'd16);
        for (int n = 0; n < q0.size() && n < 16; n++) begin
            check($sformatf("%s_bin%0d", tag, n), q0[n].data,
                  {(mode == 0) ? 32'h4040_0000 : fp(3 * n), 32'h40C0_0000});
            check($sformatf("%s_nxt%0d", tag, n), 64'(q0[n].nxt), 64'(n == 0));
        end
        if (q0.size() > 0) check({tag, "_latency"}, 64'(q0[0].cyc - startCyc), 64'd12);
        check({tag, "_busy_end"}, 64'(ifc.busy), 64'd0);
        q0.delete();
    endtask

    initial begin
        ifc.in_valid = 0; ifc.next = 0; ifc.clear = 0; ifc.in = '0;
        ifc1.in_valid = 0; ifc1.next = 0; ifc1.clear = 0; ifc1.in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_next_out", 64'(ifc.next_out), 64'd0);
        check("rst_err", 64'(ifc.err), 64'd0);
        check("rst_out", ifc.out, 64'd0);
        reset = 1'b1;
        idle(2);

        // three constant frames back to back
        sendFrame(0, 0, b0); sendFrame(0, 0, b0); sendFrame(0, 0, b0);
        expectFrame("t1", 0, b0);

        // bin-dependent data, no idle between frames
        sendFrame(1, 0, b0); sendFrame(1, 0, b0); sendFrame(1, 0, b0);
        expectFrame("t2", 1, b0);

        // random in_valid gaps inside frames
        sendFrame(0, 30, b0); sendFrame(0, 30, b0); sendFrame(0, 30, b0);
        expectFrame("t3", 0, b0);

        // clear after two channels; the sample in the clear cycle is dropped
        sendFrame(0, 0, b0); sendFrame(0, 0, b0);
        drive(1'b1, 1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000);
        idle(1);
        check("t4_busy_after_clear", 64'(ifc.busy), 64'd0);
        idle(15);
        check("t4_no_leftover", 64'(q0.size()), 64'd0);
        sendFrame(0, 0, b0); sendFrame(0, 0, b0); sendFrame(0, 0, b0);
        expectFrame("t4", 0, b0);
        check("t4_err", 64'(ifc.err), 64'd0);

        // reset in the middle of the second channel
        sendFrame(0, 0, b0);
        for (int k = 0; k < 6; k++) drive(1'b1, k == 0, 1'b0, 32'h3F80_0000, 32'h4000_0000);
        @(negedge clk);
        ifc.in_valid = 1'b0; ifc.next = 1'b0;
        reset = 1'b0;
        #1;
        check("t5_busy_in_rst", 64'(ifc.busy), 64'd0);
        check("t5_ov_in_rst", 64'(ifc.out_valid), 64'd0);
        @(negedge clk);
        check("t5_ov_in_rst2", 64'(ifc.out_valid), 64'd0);
        reset = 1'b1;
        idle(2);
        q0.delete();
        sendFrame(0, 0, b0); sendFrame(0, 0, b0); sendFrame(0, 0, b0);
        expectFrame("t5", 0, b0);

        // next at bin 5 sets a sticky error
        check("t6_err_clean", 64'(ifc.err), 64'd0);
        for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 1'b0, 32'h3F80_0000, 32'h4000_0000);
        drive(1'b1, 1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000);
        idle(1);
        check("t6_err_set", 64'(ifc.err), 64'd1);
        idle(5);
        check("t6_err_sticky", 64'(ifc.err), 64'd1);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        idle(1);
        check("t6_err_reset", 64'(ifc.err), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000);
        idle(1);
        check("t6_err_nonext", 64'(ifc.err), 64'd1);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        idle(14);
        q0.delete();

        // single-channel build passes samples straight through
        check("t7_idle_q1", 64'(q1.size()), 64'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ifc1.in_valid = 1'b1;
            ifc1.next     = (k == 0);
            ifc1.in       = {fp(k + 1), fp(k)};
            if (k == 0) b0 = cyc + 1;
        end
        @(negedge clk);
        ifc1.in_valid = 1'b0; ifc1.next = 1'b0;
        idle(20);
        check("t7_count", 64'(q1.size()), 64'd16);
        for (int n = 0; n < q1.size() && n < 16; n++) begin
            check($sformatf("t7_bin%0d", n), q1[n].data, {fp(n + 1), fp(n)});
            check($sformatf("t7_nxt%0d", n), 64'(q1[n].nxt), 64'(n == 0));
        end
        if (q1.size() > 0) check("t7_latency", 64'(q1[0].cyc - b0), 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_bin_accumulator.md
Name: complex_bin_accumulator

Overview:
- Downstream of the complex multipliers in the frequency-domain convolution path.
- Receives the per-channel streams of pointwise complex products, one FFT frame of FFT_N bins per input channel.
- Accumulates bin-wise across NUM_CH input channels into an on-chip bin buffer.
- After the last channel, emits one summed frame to the IFFT with a next_out frame-start pulse.

Parameters:
FFT_N, 16, bins per frame; power of two; must be > ADD_LAT+1 (elaboration error otherwise)
NUM_CH, 3, channel frames summed per output frame; >= 1
ADD_LAT, 11, addfp32 latency in cycles; fixed by the adder, exposed only for checks

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort: drop partial sums, channel count to 0
in  input  complex_t (64)  product sample, {r,i} fp32
in_valid  input  1  in carries a sample this cycle
next  input  1  frame start; valid only with in_valid, marks bin 0
out  output  complex_t (64)  summed sample
out_valid  output  1  out carries a result this cycle
next_out  output  1  high with the bin-0 result of each output frame
busy  output  1  partial sums held or adds in flight
err  output  1  sticky protocol error

Behaviour:
- Reset (reset=0, async): bin_cnt=0, ch_cnt=0, state IDLE, all control pipeline valid bits 0, out=0, out_valid=0, next_out=0, busy=0, err=0.
- The addfp32 data pipeline has no reset; its contents are don't-care because the control valid bits gate every use.
- States:
  - IDLE: waits for in_valid&next, then goes to FRAME with bin_cnt=0.
  - FRAME: each accepted sample uses address bin_cnt, then bin_cnt++. Gaps (in_valid=0) are allowed.
  - At bin FFT_N-1: bin_cnt wraps to 0, ch_cnt increments (wraps to 0 at NUM_CH-1), state returns to IDLE.
- Datapath per accepted sample at cycle t:
  - Cycle t: synchronous RAM read of acc[bin].
  - t+1: both addfp32 (real, imag) take operands in(delayed 1) and acc[bin]. When ch_cnt==0 the RAM operand is forced to +0.0.
  - t+1+ADD_LAT (= t+12): sum is written to acc[bin].
  - If ch_cnt==NUM_CH-1 at acceptance, the sum is also driven on out with out_valid=1 at t+12. No write is needed; the next frame is ch 0 anyway.
  - next_out=1 only with the bin-0 result of such a frame.
  - Total latency 12 cycles, fully pipelined, 1 sample/cycle, no backpressure.
- Hazard freedom: a bin is re-read no earlier than FFT_N cycles after its previous read, and FFT_N > 12 guarantees the write has already landed. No forwarding logic.
- Control pipeline is 12 stages: {valid, last_ch, first_bin, addr}, run in parallel with the adders.
- NUM_CH=1: every frame passes through (+0.0) to out.
- Protocol errors set err (sticky until reset); the sample is still processed as bin bin_cnt:
  - next while in FRAME with bin_cnt!=0.
  - in_valid without next while in IDLE with bin_cnt==0.
- clear=1:
  - ch_cnt=0, bin_cnt=0, state IDLE.
  - In-flight control valids are zeroed: no stale out_valid, no write-back.
  - A sample arriving in the clear cycle is ignored.
  - clear has priority over simultaneous in_valid.
- busy = (state==FRAME) | (ch_cnt!=0) | any control valid in flight.
- Reset mid-frame: identical to clear, asynchronous. RAM contents are not cleared; the ch 0 override makes that safe.

Decomposition:
- Shared package/common.vh: complex_t (already present), FP_ADD_LAT=11, FP_MUL_LAT=8, FP_ZERO=32'h0.
- Sub-modules:
  - acc_bin_ram: FFT_N x 64-bit, one read port, one write port, sync read, write-first not required.
  - Two addfp32 instances, existing.

Test Plan:
- FFT_N=16, NUM_CH=3; three frames, every bin r=1.0 (0x3F800000), i=2.0 (0x40000000) -> 16 out_valid with r=3.0 (0x40400000), i=6.0 (0x40C00000). First result 12 cycles after frame-3 bin 0. next_out exactly once, with bin 0.
- Bin-dependent data in[k].r=k as fp32, back-to-back frames with no idle cycles -> out[k].r=3k, bins in order. Confirms no RAW hazard at FFT_N=16.
- Random in_valid gaps inside frames, data identical to test 1 -> same sums, out_valid only for the 16 accepted last-channel samples.
- Feed 2 channel frames, assert clear, then 3 fresh frames of 1.0 -> results 3.0, no leftover contribution, no out_valid before the new third frame.
- Assert reset low mid-frame 2, release, send 3 frames -> outputs correct; busy=0 and out_valid=0 during reset.
- next at bin 5 -> err=1 and stays 1. NUM_CH=1 build -> out equals in delayed 12 cycles.
